// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the iterative divider.
//   div_state_e : FSM state encoding (IDLE / BUSY / DONE)
//   DIV_WIDTH   : operand and result width
//   DIV_CNT_W   : width of the iteration counter (holds 0..DIV_WIDTH-1)
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring division step (purely combinational).
//   rem_i   : partial remainder before the step (always < divisor, or the
//             accumulated dividend bits when the divisor is zero)
//   bit_i   : next dividend bit, shifted into the remainder LSB
//   div_i   : divisor magnitude
//   rem_o   : partial remainder after shift / trial-subtract / restore
//   q_bit_o : quotient bit produced by this step
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  // One extra bit so the trial subtraction exposes its sign.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, div_i};

  // A restored value is below the divisor and a kept difference is below
  // the divisor too, so the upper bit is always zero and can be dropped.
  assign q_bit_o = ~diff[WIDTH];
  assign rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/div_iter.sv
// div_iter: iterative 32-bit signed/unsigned divider (DIV/DIVU) for the
// execute stage. One quotient bit per cycle, restoring radix-2.
//   clk, rst    : clock and synchronous active-high reset
//   start       : divide instruction valid in E (held by the stall)
//   signed_div  : 1 = two's complement divide, 0 = unsigned
//   a, b        : dividend and divisor, sampled only in IDLE
//   flush       : annul any in-flight divide
//   quotient    : LO result, registered, holds until next completion
//   remainder   : HI result, registered, holds until next completion
//   ready       : results valid this cycle (registered)
//   stall_div   : combinational stall request to the hazard unit
// Build option: define DIV_ZERO_FAST_EN to finish a divide by zero in one
// cycle instead of running all iterations (results are identical).
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             stall_div
);

  localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(WIDTH - 1);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0]     dvd_q, dvd_d;     // dividend bits out, quotient bits in
  logic [WIDTH-1:0]     dvs_q, dvs_d;     // divisor magnitude
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     rmd_q, rmd_d;
  logic                 ready_q, ready_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH-1:0]     step_rem;
  logic                 step_bit;
  logic [WIDTH-1:0]     quo_full;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign a_mag = (signed_div & a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_div & b[WIDTH-1]) ? -b : b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i   (rem_q),
    .bit_i   (dvd_q[WIDTH-1]),
    .div_i   (dvs_q),
    .rem_o   (step_rem),
    .q_bit_o (step_bit)
  );

  assign quo_full = {dvd_q[WIDTH-2:0], step_bit};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    ready_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start & ~flush) begin
          dvd_d  = a_mag;
          dvs_d  = b_mag;
          negq_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
          negr_d = signed_div & a[WIDTH-1];
          rem_d  = '0;
          cnt_d  = '0;
`ifdef DIV_ZERO_FAST_EN
          if (b == '0) begin
            state_d = DONE;
            quo_d   = (signed_div & a[WIDTH-1]) ? WIDTH'(1) : '1;
            rmd_d   = a;
            ready_d = 1'b1;
          end else begin
            state_d = BUSY;
          end
`else
          state_d = BUSY;
`endif
        end
      end

      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          dvd_d = quo_full;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            // Final step: sign-correct straight from the step outputs.
            state_d = DONE;
            quo_d   = negq_q ? -quo_full : quo_full;
            rmd_d   = negr_q ? -step_rem : step_rem;
            ready_d = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      ready_q <= ready_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign ready     = ready_q;
  assign stall_div = start & ~flush & (state_q != DONE);

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: self-checking bench for div_iter. Expected results are
// pushed to a queue when a divide is issued and popped when ready rises.
module tb_div_iter;

  localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_div;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         ready;
  logic         stall_div;

  int   n_checks = 0;
  int   n_pass   = 0;
  res_t exp_q[$];
  res_t last_res;

  always #5 clk = ~clk;

  div_iter dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .quotient   (quotient),
    .remainder  (remainder),
    .ready      (ready),
    .stall_div  (stall_div)
  );

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic res_t ref_div(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    res_t res;
    if (y == '0) begin
      res.q = (s && x[W-1]) ? W'(1) : '1;
      res.r = x;
    end else if (!s) begin
      res.q = x / y;
      res.r = x % y;
    end else if (x == 32'h8000_0000 && y == '1) begin
      res.q = x;
      res.r = '0;
    end else begin
      res.q = $signed(x) / $signed(y);
      res.r = $signed(x) % $signed(y);
    end
    return res;
  endfunction

  // Called just after operands are driven in cycle 0; returns at the
  // negedge of the ready cycle. Operands are scrambled during BUSY.
  task automatic wait_ready(input string tag, input int lat);
    int   cyc = 0;
    int   stall_hi = 0;
    bit   seen = 0;
    res_t e;
    @(negedge clk);
    while (!seen && cyc <= 100) begin
      if (ready) begin
        seen = 1;
      end else begin
        if (stall_div) stall_hi++;
        if (cyc >= 1) begin
          a = $urandom;
          b = $urandom;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check_val({tag, ".lat"}, W'(cyc), W'(lat));
    check_val({tag, ".stall_cycles"}, W'(stall_hi), W'(lat));
    check_val({tag, ".stall_done"}, W'(stall_div), W'(0));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val({tag, ".q"}, quotient, e.q);
      check_val({tag, ".r"}, remainder, e.r);
      last_res = e;
      $display("div %s: q=0x%08h r=0x%08h lat=%0d", tag, quotient, remainder, cyc);
    end else begin
      check_val({tag, ".queue"}, W'(0), W'(1));
    end
  endtask

  // Issue a divide back-to-back with whatever preceded it (start is held).
  task automatic run_div(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input res_t exp);
    @(posedge clk);
    #1;
    start      = 1'b1;
    signed_div = s;
    a          = x;
    b          = y;
    exp_q.push_back(exp);
    wait_ready(tag, (y == '0) ? ZLAT : 33);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rx, ry;
    logic         rs;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; flush = 1'b0;
    last_res = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("reset.q", quotient, '0);
    check_val("reset.r", remainder, '0);
    check_val("reset.ready", W'(ready), W'(0));
    check_val("reset.stall", W'(stall_div), W'(0));

    run_div("divu_100_7",   32'd100,        32'd7,          1'b0, '{32'd14, 32'd2});
    run_div("div_m7_2",     32'hFFFF_FFF9,  32'd2,          1'b1, '{32'hFFFF_FFFD, 32'hFFFF_FFFF});
    run_div("div_7_m2",     32'd7,          32'hFFFF_FFFE,  1'b1, '{32'hFFFF_FFFD, 32'd1});
    run_div("div_min_m1",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, '{32'h8000_0000, 32'd0});
    run_div("divu_min_m1",  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, '{32'd0, 32'h8000_0000});
    run_div("divu_5_0",     32'd5,          32'd0,          1'b0, '{32'hFFFF_FFFF, 32'd5});
    run_div("div_m7_0",     32'hFFFF_FFF9,  32'd0,          1'b1, '{32'd1, 32'hFFFF_FFF9});

    for (int i = 0; i < 6; i++) begin
      rx = $urandom;
      ry = (i % 2 == 0) ? W'($urandom_range(1, 1000)) : $urandom;
      rs = 1'($urandom_range(0, 1));
      run_div($sformatf("rand%0d", i), rx, ry, rs, ref_div(rx, ry, rs));
    end

    // Idle gap with start low.
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check_val("idle.stall", W'(stall_div), W'(0));
    check_val("idle.ready", W'(ready), W'(0));

    // Flush at cycle 10, then a fresh divide starting in cycle 11.
    @(posedge clk);
    #1;
    start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check_val("flush.stall", W'(stall_div), W'(0));
    @(posedge clk);
    #1;
    flush = 1'b0; a = 32'd20; b = 32'd3;
    exp_q.push_back('{32'd6, 32'd2});
    #1;
    check_val("flush.q_hold", quotient, last_res.q);
    check_val("flush.r_hold", remainder, last_res.r);
    check_val("flush.ready", W'(ready), W'(0));
    check_val("flush.stall_idle", W'(stall_div), W'(1));
    wait_ready("flush_20_3", 33);

    // Reset in cycle 5 of a divide; a new divide follows immediately.
    @(posedge clk);
    #1;
    start = 1'b1; signed_div = 1'b1; a = 32'hFFFF_FFF9; b = 32'd2;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; signed_div = 1'b0; a = 32'd100; b = 32'd7;
    exp_q.push_back('{32'd14, 32'd2});
    #1;
    check_val("rst.q", quotient, '0);
    check_val("rst.r", remainder, '0);
    check_val("rst.ready", W'(ready), W'(0));
    check_val("rst.stall", W'(stall_div), W'(1));
    wait_ready("rst_100_7", 33);

    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
